// File: rtl/systolic_pe.sv
// Output-stationary systolic MAC cell: forwards operands south/east, accumulates a k_len-long dot
// product, and shifts its result down a drain chain. Define SYSTOLIC_PE_SAT_EN to saturate instead of wrap.
module systolic_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [CNT_W-1:0]  k_len,
    input  logic [DATA_W-1:0] in_col,
    input  logic [DATA_W-1:0] in_row,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_col,
    output logic [DATA_W-1:0] out_row,
    output logic              out_valid,
    input  logic              drain,
    input  logic [ACC_W-1:0]  sum_in,
    input  logic              sum_in_valid,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              sat
);

    localparam int PROD_W = 2 * DATA_W;

    if (ACC_W < PROD_W) begin : g_acc_w_check
        $error("systolic_pe: ACC_W must be at least 2*DATA_W");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, READY, DRAIN} state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n, result, result_n, sum_out_n;
    logic [CNT_W-1:0]   cnt, cnt_n, k_reg, k_n, k_eff, cnt_inc;
    logic               sum_out_valid_n, overrun_n, sat_n;
    logic [PROD_W-1:0]  col_ext, row_ext, prod_raw;
    logic [ACC_W-1:0]   product, acc_sum;
    logic               acc_ovf;

    // The low 2*DATA_W bits of a product of extended operands are exact for either signedness.
    always_comb begin
        if (SIGNED) begin
            col_ext = {{DATA_W{in_col[DATA_W-1]}}, in_col};
            row_ext = {{DATA_W{in_row[DATA_W-1]}}, in_row};
        end else begin
            col_ext = {{DATA_W{1'b0}}, in_col};
            row_ext = {{DATA_W{1'b0}}, in_row};
        end
        prod_raw = col_ext * row_ext;
        if (SIGNED) product = ACC_W'($signed(prod_raw));
        else        product = ACC_W'(prod_raw);
    end

`ifdef SYSTOLIC_PE_SAT_EN
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] bound;

    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, product};
        if (SIGNED) begin
            acc_ovf = (acc[ACC_W-1] == product[ACC_W-1]) && (sum_wide[ACC_W-1] != acc[ACC_W-1]);
            bound   = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_ovf = sum_wide[ACC_W];
            bound   = '1;
        end
        acc_sum = acc_ovf ? bound : sum_wide[ACC_W-1:0];
    end
`else
    assign acc_sum = acc + product;
    assign acc_ovf = 1'b0;
`endif

    assign busy = (state == ACCUM) || (state == READY);

    always_comb begin
        // NOTE: every target gets a default first; a path that skips one would infer a latch.
        state_n         = state;
        acc_n           = acc;
        cnt_n           = cnt;
        k_n             = k_reg;
        result_n        = result;
        sum_out_n       = sum_in;
        sum_out_valid_n = sum_in_valid;
        overrun_n       = overrun;
        sat_n           = sat;
        k_eff           = (k_len == '0) ? CNT_W'(1) : k_len;
        cnt_inc         = cnt + CNT_W'(1);

        if (clear) begin
            state_n         = IDLE;
            acc_n           = '0;
            cnt_n           = '0;
            overrun_n       = 1'b0;
            sat_n           = 1'b0;
            sum_out_n       = sum_out;
            sum_out_valid_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    k_n   = k_eff;
                    acc_n = product;
                    cnt_n = CNT_W'(1);
                    if (k_eff == CNT_W'(1)) begin
                        result_n = product;
                        state_n  = READY;
                    end else begin
                        state_n  = ACCUM;
                    end
                end
                ACCUM: if (in_valid) begin
                    sat_n = sat | acc_ovf;
                    if (cnt_inc == k_reg) begin
                        result_n = acc_sum;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = READY;
                    end else begin
                        acc_n    = acc_sum;
                        cnt_n    = cnt_inc;
                    end
                end
                READY: begin
                    // The cell owns the chain slot here, so upstream traffic is not passed on.
                    sum_out_n       = sum_out;
                    sum_out_valid_n = 1'b0;
                    if (in_valid) overrun_n = 1'b1;
                    if (drain) begin
                        sum_out_n       = result;
                        sum_out_valid_n = 1'b1;
                        state_n         = DRAIN;
                    end
                end
                DRAIN: if (!drain) begin
                    state_n         = IDLE;
                    sum_out_valid_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_col       <= '0;
            out_row       <= '0;
            out_valid     <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            k_reg         <= '0;
            result        <= '0;
            sum_out       <= '0;
            sum_out_valid <= 1'b0;
            overrun       <= 1'b0;
            sat           <= 1'b0;
        end else begin
            out_col       <= in_col;
            out_row       <= in_row;
            out_valid     <= in_valid;
            acc           <= acc_n;
            cnt           <= cnt_n;
            k_reg         <= k_n;
            result        <= result_n;
            sum_out       <= sum_out_n;
            sum_out_valid <= sum_out_valid_n;
            overrun       <= overrun_n;
            sat           <= sat_n;
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// Scoreboard bench for systolic_pe: a 3-cell signed chain plus one unsigned 32-bit accumulator cell.
module tb_systolic_pe;

    localparam int DW = 16;
    localparam int AW = 40;
    localparam int CW = 8;
    localparam int UW = 32;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          clear = 1'b0;
    logic          drain = 1'b0;
    logic [CW-1:0] k_len = '0;

    logic [DW-1:0] col [3];
    logic [DW-1:0] row [3];
    logic          vin [3];
    logic [DW-1:0] ocol [3];
    logic [DW-1:0] orow [3];
    logic          ovld [3];
    logic          p_busy [3];
    logic          p_ovr [3];
    logic          p_sat [3];
    logic [AW-1:0] sum [4];
    logic          sval [4];

    logic [DW-1:0] uc = '0, ur = '0;
    logic          uv = 1'b0, udrain = 1'b0;
    logic [CW-1:0] uk = '0;
    logic [DW-1:0] u_ocol, u_orow;
    logic          u_ovld, u_sval, u_busy, u_ovr, u_sat;
    logic [UW-1:0] u_sum;
    logic [UW-1:0] u_zero = '0;

    logic [AW-1:0] exp_q [$];
    logic [UW-1:0] u_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sum[0]  = '0;
    assign sval[0] = 1'b0;

    for (genvar i = 0; i < 3; i++) begin : g_pe
        systolic_pe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SIGNED(1'b1)) u_pe (
            .clk(clk), .rst(rst), .clear(clear), .k_len(k_len),
            .in_col(col[i]), .in_row(row[i]), .in_valid(vin[i]),
            .out_col(ocol[i]), .out_row(orow[i]), .out_valid(ovld[i]),
            .drain(drain), .sum_in(sum[i]), .sum_in_valid(sval[i]),
            .sum_out(sum[i+1]), .sum_out_valid(sval[i+1]),
            .busy(p_busy[i]), .overrun(p_ovr[i]), .sat(p_sat[i])
        );
    end

    systolic_pe #(.DATA_W(DW), .ACC_W(UW), .CNT_W(CW), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst), .clear(1'b0), .k_len(uk),
        .in_col(uc), .in_row(ur), .in_valid(uv),
        .out_col(u_ocol), .out_row(u_orow), .out_valid(u_ovld),
        .drain(udrain), .sum_in(u_zero), .sum_in_valid(1'b0),
        .sum_out(u_sum), .sum_out_valid(u_sval),
        .busy(u_busy), .overrun(u_ovr), .sat(u_sat)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] s40(input longint v);
        logic [63:0] w;
        w = v;
        return w[AW-1:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input int i, input logic [DW-1:0] c, input logic [DW-1:0] r);
        col[i] = c;
        row[i] = r;
        vin[i] = 1'b1;
        tick(1);
        vin[i] = 1'b0;
    endtask

    task automatic u_beat(input logic [DW-1:0] c, input logic [DW-1:0] r);
        uc = c;
        ur = r;
        uv = 1'b1;
        tick(1);
        uv = 1'b0;
    endtask

    task automatic drain_pulse();
        drain = 1'b1;
        tick(1);
        drain = 1'b0;
        tick(1);
    endtask

    task automatic u_drain_pulse();
        udrain = 1'b1;
        tick(1);
        udrain = 1'b0;
        tick(1);
    endtask

    // Monitors: every valid beat on a chain output must match the oldest expected result.
    always @(negedge clk) begin
        if (sval[3] === 1'b1) begin
            if (exp_q.size() == 0) check("sb_extra_sum", sval[3], 1'b0);
            else                   check("sb_sum", sum[3], exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (u_sval === 1'b1) begin
            if (u_q.size() == 0) check("u_sb_extra_sum", u_sval, 1'b0);
            else                 check("u_sb_sum", u_sum, u_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [DW-1:0] ca  [7] = '{16'd1, 16'd99, 16'd99, 16'd3, 16'd5, 16'd99, 16'd7};
        logic [DW-1:0] ra  [7] = '{16'd2, 16'd99, 16'd99, 16'd4, 16'd6, 16'd99, 16'd8};
        logic [UW-1:0] u_exp_sum;
        logic          u_exp_sat;

        for (int i = 0; i < 3; i++) begin
            col[i] = '0;
            row[i] = '0;
            vin[i] = 1'b0;
        end
        tick(2);
        check("rst_sum_valid", sval[3], 0);
        check("rst_sum", sum[3], 0);
        check("rst_busy", p_busy[2], 0);
        check("rst_out_valid", ovld[2], 0);
        check("rst_overrun", p_ovr[2], 0);
        check("rst_sat", p_sat[2], 0);
        check("rst_u_busy", u_busy, 0);
        rst = 1'b0;
        tick(1);

        // Three-term signed dot product: 6 - 20 + 7 = -7
        k_len = 8'd3;
        beat(2, 16'd2, 16'd3);
        check("k3_busy_first", p_busy[2], 1);
        check("fwd_col", ocol[2], 2);
        check("fwd_row", orow[2], 3);
        check("fwd_valid", ovld[2], 1);
        beat(2, 16'hFFFC, 16'd5);
        beat(2, 16'd7, 16'd1);
        check("k3_busy_ready", p_busy[2], 1);
        exp_q.push_back(s40(-7));
        drain_pulse();
        check("k3_idle_after_drain", p_busy[2], 0);
        check("k3_valid_dropped", sval[3], 0);

        // k_len of 0 behaves as 1
        k_len = 8'd0;
        beat(2, 16'd6, 16'd7);
        check("k0_busy", p_busy[2], 1);
        exp_q.push_back(s40(42));
        drain_pulse();

        // Gapped in_valid: 2 + 12 + 30 + 56 = 100, gap operands ignored
        k_len = 8'd4;
        for (int t = 0; t < 7; t++) begin
            col[2] = ca[t];
            row[2] = ra[t];
            vin[2] = pat[t];
            tick(1);
            check("gap_out_valid", ovld[2], pat[t]);
        end
        vin[2] = 1'b0;
        check("gap_busy_ready", p_busy[2], 1);
        exp_q.push_back(s40(100));
        drain_pulse();

        // Overrun in READY, then clear aborts a partial sum
        k_len = 8'd1;
        beat(2, 16'd3, 16'd5);
        check("ovr_clean", p_ovr[2], 0);
        beat(2, 16'd9, 16'd9);
        check("ovr_set", p_ovr[2], 1);
        check("ovr_still_ready", p_busy[2], 1);
        exp_q.push_back(s40(15));
        drain_pulse();
        check("ovr_sticky", p_ovr[2], 1);
        k_len = 8'd2;
        beat(2, 16'd1, 16'd1);
        check("clr_pre_busy", p_busy[2], 1);
        clear  = 1'b1;
        col[2] = 16'd2;
        row[2] = 16'd2;
        vin[2] = 1'b1;
        tick(1);
        clear  = 1'b0;
        vin[2] = 1'b0;
        check("clr_idle", p_busy[2], 0);
        check("clr_overrun", p_ovr[2], 0);
        beat(2, 16'd4, 16'd4);
        beat(2, 16'd1, 16'd2);
        exp_q.push_back(s40(18));
        drain_pulse();

        // Three-cell chain readout: 30, 20, 10 on consecutive cycles
        k_len = 8'd1;
        col[0] = 16'd5; row[0] = 16'd2;
        col[1] = 16'd4; row[1] = 16'd5;
        col[2] = 16'd6; row[2] = 16'd5;
        for (int i = 0; i < 3; i++) vin[i] = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) vin[i] = 1'b0;
        for (int i = 0; i < 3; i++) check("chain_ready", p_busy[i], 1);
        exp_q.push_back(s40(30));
        exp_q.push_back(s40(20));
        exp_q.push_back(s40(10));
        drain = 1'b1;
        tick(3);
        drain = 1'b0;
        tick(1);
        check("chain_idle", p_busy[0], 0);
        check("chain_valid_dropped", sval[3], 0);

        // Unsigned 0xFFFF*0xFFFF three times into a 32-bit accumulator
`ifdef SYSTOLIC_PE_SAT_EN
        u_exp_sum = 32'hFFFF_FFFF;
        u_exp_sat = 1'b1;
`else
        u_exp_sum = 32'hFFFA_0003;
        u_exp_sat = 1'b0;
`endif
        uk = 8'd3;
        for (int t = 0; t < 3; t++) u_beat(16'hFFFF, 16'hFFFF);
        check("u_busy_ready", u_busy, 1);
        check("u_sat_flag", u_sat, u_exp_sat);
        u_q.push_back(u_exp_sum);
        u_drain_pulse();

        // Asynchronous reset in the middle of an accumulation
        uk = 8'd3;
        uc = 16'h1234;
        ur = 16'h0002;
        uv = 1'b1;
        tick(1);
        check("u_accum_busy", u_busy, 1);
        check("u_accum_out_valid", u_ovld, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", u_busy, 0);
        check("arst_out_valid", u_ovld, 0);
        check("arst_out_col", u_ocol, 0);
        check("arst_sat", u_sat, 0);
        check("arst_sum_valid", u_sval, 0);
        uv = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("post_rst_busy", u_busy, 0);
        check("post_rst_out_valid", u_ovld, 0);
        check("post_rst_sum_valid", u_sval, 0);
        uk = 8'd2;
        u_beat(16'd3, 16'd5);
        u_beat(16'd1, 16'd1);
        u_q.push_back(32'd16);
        u_drain_pulse();

        tick(3);
        check("sb_empty", exp_q.size(), 0);
        check("u_sb_empty", u_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 Parameter DATA_W, default 16, operand width.
REQ-002 Parameter ACC_W, default 40, accumulator and result width; SHALL be >= 2*DATA_W.
REQ-003 Parameter CNT_W, default 8, width of the dot-product length counter.
REQ-004 Parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 clear  in  1  synchronous abort: drop the partial sum, return to IDLE.
REQ-008 k_len  in  CNT_W  dot-product length; 0 is treated as 1.
REQ-009 in_col, in_row  in  DATA_W each  operands from the north and west neighbours.
REQ-010 in_valid  in  1  qualifies in_col/in_row.
REQ-011 out_col, out_row  out  DATA_W each  operands forwarded to the south and east neighbours.
REQ-012 out_valid  out  1  forwarded in_valid.
REQ-013 drain  in  1  array-wide result readout enable.
REQ-014 sum_in  in  ACC_W, sum_in_valid  in  1  result chain from the upstream PE.
REQ-015 sum_out  out  ACC_W, sum_out_valid  out  1  result chain to the downstream PE.
REQ-016 busy  out  1  high in ACCUM or READY.
REQ-017 overrun  out  1  sticky: in_valid was seen while in READY.
REQ-018 sat  out  1  sticky: accumulator saturation occurred.

Function
REQ-019 out_col, out_row and out_valid SHALL register in_col, in_row and in_valid every cycle with 1-cycle latency, independent of state, clear and drain.
REQ-020 product = in_col*in_row, 2*DATA_W wide, signed or unsigned per SIGNED, sign- or zero-extended to ACC_W; accumulation SHALL wrap modulo 2^ACC_W unless REQ-030 applies.
REQ-021 FSM states: IDLE, ACCUM, READY, DRAIN.
REQ-022 IDLE: on in_valid, sample k_len, set acc=product and cnt=1; go to READY (result=product) if the effective k_len is 1, else go to ACCUM.
REQ-023 ACCUM: on in_valid, acc+=product and cnt++; when the updated cnt equals the sampled k_len, latch result=acc+product, zero acc and cnt, and go to READY; without in_valid, hold.
REQ-024 READY: hold result; in_valid is ignored and sets overrun; on drain=1, sum_out<=result, sum_out_valid<=1, and go to DRAIN.
REQ-025 DRAIN: each cycle sum_out<=sum_in and sum_out_valid<=sum_in_valid; on drain=0, go to IDLE with sum_out_valid<=0.
REQ-026 In IDLE and ACCUM, sum_out<=sum_in and sum_out_valid<=sum_in_valid, so upstream results pass through while drain is high.
REQ-027 clear SHALL override every transition except reset: state IDLE, acc=0, cnt=0, overrun=0, sat=0, sum_out_valid=0; a same-cycle in_valid is discarded.
REQ-028 busy SHALL be combinational from the state register.

Reset
REQ-029 While rst=1, asynchronously: all outputs 0, acc=0, cnt=0, result=0, state IDLE; a mid-operation reset SHALL lose the partial sum with no output glitch after release.

Configuration
REQ-030 Macro SYSTOLIC_PE_SAT_EN defined: each accumulate SHALL clamp to the ACC_W bound (signed max/min or unsigned max) on overflow and set sat; macro undefined: the sum wraps and sat is tied to 0.

Verification
REQ-031 DATA_W=16, SIGNED=1, k_len=3, operand pairs (2,3),(-4,5),(7,1) -> READY after the 3rd beat, result=-7; drain pulse -> sum_out=-7 with sum_out_valid for 1 cycle.
REQ-032 k_len=0, single pair (6,7) -> READY on the next cycle, result=42.
REQ-033 k_len=4, in_valid gapped as 1,0,0,1,1,0,1 -> exactly 4 products summed; out_valid mirrors the pattern delayed by 1 cycle.
REQ-034 In READY, one extra in_valid -> overrun=1 and result unchanged; clear -> overrun=0, state IDLE.
REQ-035 Chain of 3 PEs, all READY with 10,20,30, drain high for 3 cycles -> last sum_out yields 30,20,10 on consecutive cycles.
REQ-036 ACC_W=32, SIGNED=0, repeated 0xFFFF*0xFFFF -> wraps without SYSTOLIC_PE_SAT_EN, clamps to 0xFFFFFFFF with sat=1 with it; rst asserted mid-ACCUM -> all outputs 0 immediately.
